// File: rtl/irq_vector_decoder.sv
// Registered interrupt decoder: latches the winning encoder line, requests the CPU,
// returns a one-hot active-low acknowledge, then waits for the source to withdraw.
//
// state | meaning
// IDLE  | waiting for an enabled request from the encoder
// REQ   | out_irq high, idx frozen, waiting for CPU ack or source withdraw
// ACK   | out_ack_n[idx] low for ACK_CYCLES clocks
// HOLD  | waiting for the acknowledged source to drop before re-arming
module irq_vector_decoder #(
   parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
   parameter int          VECTOR_STRIDE = 4,
   parameter int          ACK_CYCLES    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  in_code_n,
   input  logic        in_gs_n,
   input  logic        in_enable_n,
   input  logic        in_cpu_ack,
   output logic        out_irq,
   output logic [2:0]  out_index,
   output logic [31:0] out_vector,
   output logic [7:0]  out_ack_n,
   output logic        out_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam logic [31:0] STRIDE_W  = 32'(VECTOR_STRIDE);
   localparam logic [3:0]  CNT_LOAD  = 4'(ACK_CYCLES - 1);

   generate
      if (ACK_CYCLES < 1 || ACK_CYCLES > 15) begin : g_bad_ack_cycles
         $error("ACK_CYCLES must be in 1..15");
      end
   endgenerate

   state_t     state, state_nxt;
   logic [2:0] idx, idx_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [2:0] line_idx;

   assign line_idx = ~in_code_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= 3'd0;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (!in_enable_n && !in_gs_n) begin
               idx_nxt   = line_idx;
               state_nxt = REQ;
            end
         end
         REQ: begin
            // CPU ack wins over a simultaneous withdraw
            if (in_cpu_ack) begin
               cnt_nxt   = CNT_LOAD;
               state_nxt = ACK;
            end else if (in_gs_n) begin
               state_nxt = IDLE;
            end
         end
         ACK: begin
            if (cnt == 4'd0) begin
               state_nxt = HOLD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         HOLD: begin
            if (in_gs_n || (line_idx != idx) || in_enable_n) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decode only registered state and idx
   always_comb begin
      out_irq    = (state == REQ);
      out_busy   = (state != IDLE);
      out_index  = idx;
      out_vector = VECTOR_BASE + {29'b0, idx} * STRIDE_W;
      out_ack_n  = 8'hFF;
      if (state == ACK) begin
         out_ack_n[idx] = 1'b0;
      end
   end

endmodule

// File: tb/tb_irq_vector_decoder.sv
// Directed bench for irq_vector_decoder: default instance plus two parameter variants.
module tb_irq_vector_decoder;

   logic        clk;
   logic        rst_n;
   logic [2:0]  in_code_n;
   logic        in_gs_n;
   logic        in_enable_n;
   logic        in_cpu_ack;

   logic        irq0, irq1, irq15;
   logic [2:0]  index0, index1, index15;
   logic [31:0] vector0, vector1, vector15;
   logic [7:0]  ack_n0, ack_n1, ack_n15;
   logic        busy0, busy1, busy15;

   int checks = 0;
   int errors = 0;

   irq_vector_decoder dut (
      .clk(clk), .rst_n(rst_n), .in_code_n(in_code_n), .in_gs_n(in_gs_n),
      .in_enable_n(in_enable_n), .in_cpu_ack(in_cpu_ack),
      .out_irq(irq0), .out_index(index0), .out_vector(vector0),
      .out_ack_n(ack_n0), .out_busy(busy0)
   );

   irq_vector_decoder #(.VECTOR_BASE(32'hFFFF_FFF0), .VECTOR_STRIDE(4), .ACK_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_code_n(in_code_n), .in_gs_n(in_gs_n),
      .in_enable_n(in_enable_n), .in_cpu_ack(in_cpu_ack),
      .out_irq(irq1), .out_index(index1), .out_vector(vector1),
      .out_ack_n(ack_n1), .out_busy(busy1)
   );

   irq_vector_decoder #(.VECTOR_BASE(32'hFFFF_FFF0), .VECTOR_STRIDE(4), .ACK_CYCLES(15)) dut15 (
      .clk(clk), .rst_n(rst_n), .in_code_n(in_code_n), .in_gs_n(in_gs_n),
      .in_enable_n(in_enable_n), .in_cpu_ack(in_cpu_ack),
      .out_irq(irq15), .out_index(index15), .out_vector(vector15),
      .out_ack_n(ack_n15), .out_busy(busy15)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n       = 1'b0;
      in_code_n   = 3'b111;
      in_gs_n     = 1'b1;
      in_enable_n = 1'b0;
      in_cpu_ack  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      in_code_n   = 3'b111;
      in_gs_n     = 1'b1;
      in_enable_n = 1'b0;
      in_cpu_ack  = 1'b0;
      #1;
      checks++;
      if ({irq0, index0, vector0, ack_n0, busy0} !== {1'b0, 3'd0, 32'h100, 8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: irq=%0b idx=%0d vec=%h ack_n=%h busy=%0b, want 0 0 00000100 ff 0",
                  irq0, index0, vector0, ack_n0, busy0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // drive into ACK, then assert reset between edges
      in_code_n = 3'b010;
      in_gs_n   = 1'b0;
      @(negedge clk);
      in_cpu_ack = 1'b1;
      @(negedge clk);
      in_cpu_ack = 1'b0;
      checks++;
      if (ack_n0 !== 8'hDF) begin
         errors++;
         $display("FAIL reset_pre_ack: ack_n=%h want df", ack_n0);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({irq0, index0, vector0, ack_n0, busy0} !== {1'b0, 3'd0, 32'h100, 8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_ack: irq=%0b idx=%0d vec=%h ack_n=%h busy=%0b, want 0 0 00000100 ff 0",
                  irq0, index0, vector0, ack_n0, busy0);
      end
      in_gs_n   = 1'b1;
      in_code_n = 3'b111;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || irq0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%0b irq=%0b want 0 0", busy0, irq0);
      end
   endtask

   task automatic test_single_request();
      in_code_n = 3'b010;
      in_gs_n   = 1'b0;
      @(negedge clk);
      checks++;
      if ({irq0, index0, vector0, busy0} !== {1'b1, 3'd5, 32'h114, 1'b1}) begin
         errors++;
         $display("FAIL single_req: irq=%0b idx=%0d vec=%h busy=%0b want 1 5 00000114 1",
                  irq0, index0, vector0, busy0);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (irq0 !== 1'b1 || vector0 !== 32'h114 || ack_n0 !== 8'hFF) begin
         errors++;
         $display("FAIL single_req_wait: irq=%0b vec=%h ack_n=%h want 1 00000114 ff", irq0, vector0, ack_n0);
      end
      in_cpu_ack = 1'b1;
      @(negedge clk);
      in_cpu_ack = 1'b0;
      checks++;
      if (irq0 !== 1'b0 || ack_n0 !== 8'hDF) begin
         errors++;
         $display("FAIL single_ack_1: irq=%0b ack_n=%h want 0 df", irq0, ack_n0);
      end
      @(negedge clk);
      checks++;
      if (ack_n0 !== 8'hDF) begin
         errors++;
         $display("FAIL single_ack_2: ack_n=%h want df", ack_n0);
      end
      @(negedge clk);
      checks++;
      if (ack_n0 !== 8'hFF || busy0 !== 1'b1 || irq0 !== 1'b0) begin
         errors++;
         $display("FAIL single_hold: ack_n=%h busy=%0b irq=%0b want ff 1 0", ack_n0, busy0, irq0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b1 || irq0 !== 1'b0 || ack_n0 !== 8'hFF) begin
         errors++;
         $display("FAIL single_hold_stays: busy=%0b irq=%0b ack_n=%h want 1 0 ff", busy0, irq0, ack_n0);
      end
      in_gs_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0) begin
         errors++;
         $display("FAIL single_release: busy=%0b want 0", busy0);
      end
   endtask

   task automatic test_withdraw();
      int seen;
      in_code_n = 3'b100;
      in_gs_n   = 1'b0;
      @(negedge clk);
      checks++;
      if (irq0 !== 1'b1 || index0 !== 3'd3 || vector0 !== 32'h10C) begin
         errors++;
         $display("FAIL withdraw_req: irq=%0b idx=%0d vec=%h want 1 3 0000010c", irq0, index0, vector0);
      end
      in_gs_n = 1'b1;
      seen = 0;
      @(negedge clk);
      checks++;
      if (irq0 !== 1'b0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL withdraw_drop: irq=%0b busy=%0b want 0 0", irq0, busy0);
      end
      for (int i = 0; i < 4; i++) begin
         if (ack_n0 !== 8'hFF) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL withdraw_no_ack: ack cycles=%0d want 0", seen);
      end
      in_gs_n = 1'b0;
      @(negedge clk);
      in_gs_n    = 1'b1;
      in_cpu_ack = 1'b1;
      @(negedge clk);
      in_cpu_ack = 1'b0;
      checks++;
      if (ack_n0 !== 8'hF7 || irq0 !== 1'b0) begin
         errors++;
         $display("FAIL withdraw_ack_priority: ack_n=%h irq=%0b want f7 0", ack_n0, irq0);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || ack_n0 !== 8'hFF) begin
         errors++;
         $display("FAIL withdraw_ack_done: busy=%0b ack_n=%h want 0 ff", busy0, ack_n0);
      end
   endtask

   task automatic test_enable_gating();
      int bad;
      in_enable_n = 1'b1;
      in_code_n   = 3'b110;
      in_gs_n     = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (busy0 !== 1'b0 || irq0 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL enable_blocked: busy/irq high in %0d cycles want 0", bad);
      end
      in_enable_n = 1'b0;
      @(negedge clk);
      checks++;
      if (irq0 !== 1'b1 || index0 !== 3'd1 || vector0 !== 32'h104) begin
         errors++;
         $display("FAIL enable_taken: irq=%0b idx=%0d vec=%h want 1 1 00000104", irq0, index0, vector0);
      end
      in_gs_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0) begin
         errors++;
         $display("FAIL enable_cleanup: busy=%0b want 0", busy0);
      end
   endtask

   task automatic test_priority_handoff();
      in_code_n = 3'b101;
      in_gs_n   = 1'b0;
      @(negedge clk);
      checks++;
      if (index0 !== 3'd2 || vector0 !== 32'h108 || irq0 !== 1'b1) begin
         errors++;
         $display("FAIL handoff_req2: idx=%0d vec=%h irq=%0b want 2 00000108 1", index0, vector0, irq0);
      end
      in_code_n = 3'b001;
      @(negedge clk);
      checks++;
      if (index0 !== 3'd2 || vector0 !== 32'h108) begin
         errors++;
         $display("FAIL handoff_frozen: idx=%0d vec=%h want 2 00000108", index0, vector0);
      end
      in_code_n  = 3'b101;
      in_cpu_ack = 1'b1;
      @(negedge clk);
      in_cpu_ack = 1'b0;
      checks++;
      if (ack_n0 !== 8'hFB || index0 !== 3'd2) begin
         errors++;
         $display("FAIL handoff_ack: ack_n=%h idx=%0d want fb 2", ack_n0, index0);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (busy0 !== 1'b1 || ack_n0 !== 8'hFF) begin
         errors++;
         $display("FAIL handoff_hold: busy=%0b ack_n=%h want 1 ff", busy0, ack_n0);
      end
      in_code_n = 3'b001;
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0) begin
         errors++;
         $display("FAIL handoff_idle: busy=%0b want 0", busy0);
      end
      @(negedge clk);
      checks++;
      if (irq0 !== 1'b1 || index0 !== 3'd6 || vector0 !== 32'h118) begin
         errors++;
         $display("FAIL handoff_req6: irq=%0b idx=%0d vec=%h want 1 6 00000118", irq0, index0, vector0);
      end
      in_gs_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_param_sweep();
      int c1, c15, other;
      do_reset();
      in_code_n = 3'b000;
      in_gs_n   = 1'b0;
      @(negedge clk);
      checks++;
      if (irq1 !== 1'b1 || vector1 !== 32'h0000_000C || vector15 !== 32'h0000_000C) begin
         errors++;
         $display("FAIL sweep_vector_wrap: irq1=%0b vec1=%h vec15=%h want 1 0000000c 0000000c",
                  irq1, vector1, vector15);
      end
      in_cpu_ack = 1'b1;
      @(negedge clk);
      in_cpu_ack = 1'b0;
      c1 = 0;
      c15 = 0;
      other = 0;
      for (int i = 0; i < 30; i++) begin
         if (ack_n1 === 8'h7F) c1++;
         else if (ack_n1 !== 8'hFF) other++;
         if (ack_n15 === 8'h7F) c15++;
         else if (ack_n15 !== 8'hFF) other++;
         @(negedge clk);
      end
      checks++;
      if (c1 != 1 || other != 0) begin
         errors++;
         $display("FAIL sweep_ack1_width: cycles=%0d bad=%0d want 1 0", c1, other);
      end
      checks++;
      if (c15 != 15) begin
         errors++;
         $display("FAIL sweep_ack15_width: cycles=%0d want 15", c15);
      end
      checks++;
      if (busy1 !== 1'b1 || busy15 !== 1'b1) begin
         errors++;
         $display("FAIL sweep_hold: busy1=%0b busy15=%0b want 1 1", busy1, busy15);
      end
      in_gs_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_request();
      test_withdraw();
      test_enable_gating();
      test_priority_handoff();
      test_param_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
